// File: rtl/issue_sel.sv
// Issue-queue select: per-port round-robin (or fixed-priority) pick feeding a registered issue stage.
// Define ISSUE_SEL_RR_EN to build per-port rotating pointers; otherwise every port scans from entry 0.
module issue_sel #(
    parameter int ISQ_DEPTH  = 64,
    parameter int IDX_BITS   = 6,
    parameter int INST_WIDTH = 64,
    parameter int NUM_PORTS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ISQ_DEPTH-1:0]            req_vld,
    input  logic [ISQ_DEPTH*NUM_PORTS-1:0]  req_fu,
    input  logic [ISQ_DEPTH*INST_WIDTH-1:0] inst_flat,
    input  logic [NUM_PORTS-1:0]            port_rdy,
    input  logic                            flush,
    output logic [NUM_PORTS-1:0]            port_vld,
    output logic [NUM_PORTS*INST_WIDTH-1:0] port_inst,
    output logic [NUM_PORTS*IDX_BITS-1:0]   port_idx,
    output logic [ISQ_DEPTH-1:0]            set_inst_wat
);

    logic [NUM_PORTS-1:0]                 vld_q, vld_d;
    logic [NUM_PORTS-1:0][INST_WIDTH-1:0] inst_q, inst_d;
    logic [NUM_PORTS-1:0][IDX_BITS-1:0]   idx_q, idx_d;

    logic [NUM_PORTS-1:0]               able;
    logic [NUM_PORTS-1:0]               gnt;
    logic [NUM_PORTS-1:0][IDX_BITS-1:0] gnt_idx;
    logic [NUM_PORTS-1:0][IDX_BITS-1:0] start;
    logic [ISQ_DEPTH-1:0]               taken;
    logic [IDX_BITS-1:0]                cand;

`ifdef ISSUE_SEL_RR_EN
    logic [NUM_PORTS-1:0][IDX_BITS-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) ptr_d[p] = gnt_idx[p] + IDX_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign start = '0;
`endif

    // Ports pick in ascending order; 'taken' masks earlier winners so no entry issues twice.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch can be inferred.
        able   = '0;
        gnt    = '0;
        gnt_idx = '0;
        taken  = '0;
        cand   = '0;
        vld_d  = vld_q;
        inst_d = inst_q;
        idx_d  = idx_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            able[p] = rst_n && !flush && (!vld_q[p] || port_rdy[p]);
            if (vld_q[p] && port_rdy[p]) vld_d[p] = 1'b0;
            if (able[p]) begin
                for (int k = 0; k < ISQ_DEPTH; k++) begin
                    // Index arithmetic wraps naturally because ISQ_DEPTH is a power of two.
                    cand = start[p] + IDX_BITS'(k);
                    if (!gnt[p] && req_vld[cand] && !taken[cand] &&
                        req_fu[int'(cand)*NUM_PORTS + p]) begin
                        gnt[p]     = 1'b1;
                        gnt_idx[p] = cand;
                    end
                end
            end
            if (gnt[p]) begin
                taken[gnt_idx[p]] = 1'b1;
                vld_d[p]  = 1'b1;
                inst_d[p] = inst_flat[int'(gnt_idx[p])*INST_WIDTH +: INST_WIDTH];
                idx_d[p]  = gnt_idx[p];
            end
        end
        if (flush) vld_d = '0;
    end

    // NOTE: payload registers are reset too, since outputs must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            inst_q <= '0;
            idx_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
            vld_q  <= vld_d;
            inst_q <= inst_d;
            idx_q  <= idx_d;
        end
    end

    assign port_vld     = vld_q;
    assign port_inst    = inst_q;
    assign port_idx     = idx_q;
    assign set_inst_wat = taken;

endmodule

// File: doc/issue_sel.md
ISSUE_SEL -- requirements
Module: issue_sel

Interface
REQ-001 Parameter ISQ_DEPTH, default 64: number of issue-queue entries (power of two, at least 4).
REQ-002 Parameter IDX_BITS, default 6: width of an entry index, equal to log2(ISQ_DEPTH).
REQ-003 Parameter INST_WIDTH, default 64: width of the instruction payload per entry.
REQ-004 Parameter NUM_PORTS, default 4: number of function-unit issue ports (1 to 8).
REQ-005 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port req_vld, input, ISQ_DEPTH: entry is valid, operand-ready and still waiting.
REQ-009 Port req_fu, input, ISQ_DEPTH*NUM_PORTS: bit [e*NUM_PORTS+p] set means entry e may issue on port p.
REQ-010 Port inst_flat, input, ISQ_DEPTH*INST_WIDTH: entry e payload in bits [INST_WIDTH*(e+1)-1 : INST_WIDTH*e].
REQ-011 Port port_rdy, input, NUM_PORTS: function unit p accepts port p output this cycle.
REQ-012 Port flush, input, 1: synchronous squash of all in-flight selections.
REQ-013 Port port_vld, output, NUM_PORTS: port p output register holds an instruction.
REQ-014 Port port_inst, output, NUM_PORTS*INST_WIDTH: registered payload per port.
REQ-015 Port port_idx, output, NUM_PORTS*IDX_BITS: registered source entry index per port.
REQ-016 Port set_inst_wat, output, ISQ_DEPTH: combinational; one bit set per entry granted in this cycle.

Function
REQ-017 Port p shall be able to accept a grant when port_vld[p] is 0 or port_rdy[p] is 1, and flush is 0.
REQ-018 Each able port shall grant at most one entry per cycle, choosing the entry with req_vld=1 and req_fu bit set, searched upward from rr_ptr[p] with wrap from ISQ_DEPTH-1 to 0.
REQ-019 Ports shall be arbitrated in ascending order; an entry granted to a lower-numbered port shall be masked from all higher ports in the same cycle, so no entry issues twice.
REQ-020 A grant in cycle N shall load port_inst, port_idx and port_vld=1 at edge N+1 (one-cycle latency), and shall assert set_inst_wat[e] during cycle N.
REQ-021 When port_vld[p]=1, port_rdy[p]=1 and there is no new grant, port_vld[p] shall clear at the next edge; when a new grant coincides with consumption, the new payload shall replace the old one with no bubble.
REQ-022 When port_vld[p]=1 and port_rdy[p]=0, port p shall hold its payload stable and make no grant.
REQ-023 After a grant to entry e, rr_ptr[p] shall become (e+1) mod ISQ_DEPTH; it shall be unchanged when no grant occurs.
REQ-024 flush=1 shall clear all port_vld at the next edge, force set_inst_wat to 0 and suppress grants in that cycle, and leave rr_ptr unchanged.
REQ-025 An entry with req_vld=0 shall never be granted, regardless of req_fu.

Reset
REQ-026 While rst_n=0: port_vld=0, port_inst=0, port_idx=0, and every rr_ptr=0, all asynchronously.
REQ-027 set_inst_wat shall be 0 while rst_n=0; reset asserted mid-operation shall discard held payloads without a handshake.

Configuration
REQ-028 Macro ISSUE_SEL_RR_EN defined: round-robin pointers operate as specified in REQ-018 and REQ-023.
REQ-029 ISSUE_SEL_RR_EN undefined: pointer registers are not built, and every port applies fixed priority from entry 0 upward; all other behaviour is identical.

Verification (ISQ_DEPTH=8, NUM_PORTS=2, RR enabled unless noted)
REQ-030 Entries 2 and 5 are ready for port 0 only, port_rdy=11 -> cycle 0 grants 2 (set_inst_wat=0x04), cycle 1 grants 5 (0x20), port_idx[0] is 2 then 5.
REQ-031 Entry 3 is eligible for both ports and entry 6 for port 1 only -> port 0 gets 3, port 1 gets 6, set_inst_wat=0x48.
REQ-032 port_vld[1]=1, port_rdy[1]=0 for 3 cycles with entry 4 requesting port 1 -> payload held, set_inst_wat[4]=0 until port_rdy[1]=1, then back-to-back reload.
REQ-033 rr_ptr[0]=7, entries 0 and 7 requesting port 0 -> 7 is granted, then 0 on the wrap; with ISSUE_SEL_RR_EN undefined -> 0 is granted first.
REQ-034 flush=1 with both ports valid and requests pending -> port_vld=00 next cycle, set_inst_wat=0, and the pointers are unchanged.
REQ-035 rst_n is asserted asynchronously mid-stream -> all outputs become 0 immediately, and the first grant after release restarts from entry 0.
